// File: rtl/dft_pkg.sv
// Shared definitions for the 4-point DFT datapath.
// Holds the frame length, bank/word index types and the default sample
// width so the framer and later DFT stages agree on them.
package dft_pkg;

    localparam int FRAME_LEN   = 4;
    localparam int DFT_WORD_SZ = 16;

    // Selects one of the two ping-pong banks.
    typedef logic       bank_idx_t;
    // Position of a sample within a frame (0..FRAME_LEN-1).
    typedef logic [1:0] word_idx_t;

endpackage

// File: rtl/dft_input_framer_if.sv
// Handshake bundle between a sample producer / frame consumer and the
// DFT input framer.
//   i_sample, i_sample_valid, o_sample_ready : serial sample stream
//   i_clear                                  : drop partially filled frame
//   o_A..o_D, o_frame_valid, i_frame_ready   : parallel frame stream
//   o_fill_level                             : samples in the filling frame
// slave  = framer side, master = producer/consumer side.
interface dft_input_framer_if import dft_pkg::*; #(
    parameter int WORD_SZ = DFT_WORD_SZ
);
    logic [WORD_SZ-1:0] i_sample;
    logic               i_sample_valid;
    logic               o_sample_ready;
    logic               i_clear;
    logic [WORD_SZ-1:0] o_A;
    logic [WORD_SZ-1:0] o_B;
    logic [WORD_SZ-1:0] o_C;
    logic [WORD_SZ-1:0] o_D;
    logic               o_frame_valid;
    logic               i_frame_ready;
    word_idx_t          o_fill_level;

    modport slave (
        input  i_sample, i_sample_valid, i_clear, i_frame_ready,
        output o_sample_ready, o_A, o_B, o_C, o_D, o_frame_valid, o_fill_level
    );

    modport master (
        output i_sample, i_sample_valid, i_clear, i_frame_ready,
        input  o_sample_ready, o_A, o_B, o_C, o_D, o_frame_valid, o_fill_level
    );
endinterface

// File: rtl/dft_frame_bank.sv
// One FRAME_LEN x WORD_SZ register bank for the input framer.
//   i_clk, i_rst_n : clock, async active-low reset (clears all words)
//   i_we, i_idx, i_din : indexed single-word write port
//   o_words        : all words in parallel, index 0 = first sample
module dft_frame_bank import dft_pkg::*; #(
    parameter int WORD_SZ = DFT_WORD_SZ
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    input  logic                               i_we,
    input  word_idx_t                          i_idx,
    input  logic [WORD_SZ-1:0]                 i_din,
    output logic [FRAME_LEN-1:0][WORD_SZ-1:0]  o_words
);
    logic [FRAME_LEN-1:0][WORD_SZ-1:0] r_words;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_words <= '0;
        end else if (i_we) begin
            r_words[i_idx] <= i_din;
        end
    end

    assign o_words = r_words;
endmodule

// File: rtl/dft_input_framer.sv
// Serial-to-parallel front end for the 4-point DFT network.
// Groups every FRAME_LEN accepted samples into a frame, ping-ponging
// between two banks so one fills while the other waits downstream.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus            : sample stream in, frame stream out, clear, fill level
module dft_input_framer import dft_pkg::*; #(
    parameter int WORD_SZ = DFT_WORD_SZ
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    dft_input_framer_if.slave bus
);
    logic [1:0] r_full;
    bank_idx_t  r_wr_sel;
    bank_idx_t  r_rd_sel;
    word_idx_t  r_wr_idx;

    logic       w_sample_acc;
    logic       w_fill_done;
    logic       w_frame_acc;
    logic [1:0] w_we;
    logic [1:0][FRAME_LEN-1:0][WORD_SZ-1:0] w_rd_words;

    assign bus.o_sample_ready = !r_full[r_wr_sel] && !bus.i_clear;
    assign w_sample_acc       = bus.i_sample_valid && bus.o_sample_ready;
    assign w_fill_done        = w_sample_acc && (r_wr_idx == word_idx_t'(FRAME_LEN - 1));
    assign w_frame_acc        = r_full[r_rd_sel] && bus.i_frame_ready;

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_bank
            assign w_we[g] = w_sample_acc && (r_wr_sel == bank_idx_t'(g));

            dft_frame_bank #(.WORD_SZ(WORD_SZ)) u_bank (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_we    (w_we[g]),
                .i_idx   (r_wr_idx),
                .i_din   (bus.i_sample),
                .o_words (w_rd_words[g])
            );
        end
    endgenerate

    // A completing fill needs its bank empty, a frame accept needs its bank
    // full, so when both fire in one cycle they hit different banks and the
    // two flag updates never collide.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_full   <= '0;
            r_wr_sel <= '0;
            r_rd_sel <= '0;
            r_wr_idx <= '0;
        end else begin
            if (w_frame_acc) begin
                r_full[r_rd_sel] <= 1'b0;
                r_rd_sel         <= ~r_rd_sel;
            end
            if (w_fill_done) begin
                r_full[r_wr_sel] <= 1'b1;
                r_wr_sel         <= ~r_wr_sel;
            end
            // Clear blocks the sample accept, so only one of these applies.
            if (bus.i_clear) begin
                r_wr_idx <= '0;
            end else if (w_sample_acc) begin
                r_wr_idx <= r_wr_idx + word_idx_t'(1);
            end
        end
    end

    assign bus.o_frame_valid = r_full[r_rd_sel];
    assign bus.o_A           = w_rd_words[r_rd_sel][0];
    assign bus.o_B           = w_rd_words[r_rd_sel][1];
    assign bus.o_C           = w_rd_words[r_rd_sel][2];
    assign bus.o_D           = w_rd_words[r_rd_sel][3];
    assign bus.o_fill_level  = r_wr_idx;
endmodule
